// File: rtl/div_pkg.sv
// Shared definitions for the pipelined divide scheduler: defaults, sideband
// record carried beside the divider, and one restoring-division step.
package div_pkg;

  localparam int NSTAGE_DEF = 16;
  localparam int TAGW_DEF   = 4;
  localparam int TAGW_MAX   = 16;

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_e;

  typedef struct packed {
    logic                valid;
    logic                id;
    logic [TAGW_MAX-1:0] tag;
    logic                dz;
    logic                ovf;
    logic [31:0]         x1_lo;
  } sideband_t;

  typedef struct packed {
    logic [31:0] rem;
    logic [63:0] dvd;
    logic [31:0] dsr;
  } div_stage_t;

  // Dividend bits leave the top of dvd while quotient bits enter at the bottom,
  // so after 64 steps dvd holds the full quotient and rem the remainder.
  function automatic div_stage_t div_step(input div_stage_t s);
    div_stage_t  n;
    logic [32:0] acc;
    n     = s;
    acc   = {s.rem, s.dvd[63]};
    n.dvd = {s.dvd[62:0], 1'b0};
    if (acc >= {1'b0, s.dsr}) begin
      acc      = acc - {1'b0, s.dsr};
      n.dvd[0] = 1'b1;
    end
    n.rem = acc[31:0];
    return n;
  endfunction

endpackage

// File: rtl/div32.sv
// Fully pipelined 64/32 restoring divider: NSTAGE register stages, result on
// y (low 32 quotient bits) and z (remainder) NSTAGE edges after capture.
module div32
  import div_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEF
) (
  input  logic        clk,
  input  logic [63:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic [31:0] z
);

  localparam int IPS = (64 + NSTAGE - 1) / NSTAGE;

  div_stage_t stg_q [NSTAGE];
  div_stage_t stg_d [NSTAGE];

  always_comb begin
    div_stage_t cur;
    cur = '{rem: '0, dvd: x1, dsr: x2};
    for (int s = 0; s < NSTAGE; s++) begin
      for (int k = 0; k < IPS; k++) begin
        if (s * IPS + k < 64) cur = div_step(cur);
      end
      stg_d[s] = cur;
      if (s < NSTAGE - 1) cur = stg_q[s];
    end
  end

  // Datapath only; validity is tracked by the scheduler's sideband.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSTAGE; s++) stg_q[s] <= stg_d[s];
  end

  assign y = stg_q[NSTAGE-1].dvd[31:0];
  assign z = stg_q[NSTAGE-1].rem;

endmodule

// File: rtl/div_sched.sv
// Two-requester round-robin front end for a shared pipelined divider, with
// in-order registered responses, flush, and divide-by-zero/overflow flags.
module div_sched
  import div_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int TAGW   = TAGW_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            a_valid,
  input  logic            b_valid,
  output logic            a_ready,
  output logic            b_ready,
  input  logic [63:0]     a_x1,
  input  logic [63:0]     b_x1,
  input  logic [31:0]     a_x2,
  input  logic [31:0]     b_x2,
  input  logic [TAGW-1:0] a_tag,
  input  logic [TAGW-1:0] b_tag,
  input  logic            flush,
  output logic            resp_valid,
  output logic            resp_id,
  output logic [TAGW-1:0] resp_tag,
  output logic [31:0]     resp_q,
  output logic [31:0]     resp_r,
  output logic            resp_dz,
  output logic            resp_ovf,
  output logic            busy
);

  localparam int CW = $clog2(NSTAGE + 2);

  ptr_e            ptr_q, ptr_d;
  logic            issue;
  logic [63:0]     op_x1;
  logic [31:0]     op_x2;
  logic [TAGW-1:0] op_tag;
  logic [31:0]     div_y, div_z;
  sideband_t       sb_q [NSTAGE];
  sideband_t       sb_d [NSTAGE];
  logic            resp_valid_q, resp_valid_d;
  logic            resp_id_q, resp_id_d;
  logic [TAGW-1:0] resp_tag_q, resp_tag_d;
  logic [31:0]     resp_q_q, resp_q_d;
  logic [31:0]     resp_r_q, resp_r_d;
  logic            resp_dz_q, resp_dz_d;
  logic            resp_ovf_q, resp_ovf_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Handshake: an operation transfers on a cycle where valid && ready; ready is
  // never high without valid, a requester holds its operation until accepted,
  // and at most one requester is granted per cycle.
  always_comb begin
    a_ready = rstn && !flush && a_valid && (!b_valid || ptr_q == PTR_A);
    b_ready = rstn && !flush && b_valid && (!a_valid || ptr_q == PTR_B);
    issue   = a_ready || b_ready;
    op_x1   = b_ready ? b_x1  : a_x1;
    op_x2   = b_ready ? b_x2  : a_x2;
    op_tag  = b_ready ? b_tag : a_tag;
    ptr_d   = ptr_q;
    if (issue) ptr_d = a_ready ? PTR_B : PTR_A;
  end

  div32 #(.NSTAGE(NSTAGE)) u_div (
    .clk (clk),
    .x1  (op_x1),
    .x2  (op_x2),
    .y   (div_y),
    .z   (div_z)
  );

  always_comb begin
    sb_d[0].valid = issue;
    sb_d[0].id    = b_ready;
    sb_d[0].tag   = TAGW_MAX'(op_tag);
    sb_d[0].dz    = (op_x2 == '0);
    sb_d[0].ovf   = (op_x2 != '0) && (op_x1[63:32] >= op_x2);
    sb_d[0].x1_lo = op_x1[31:0];
    for (int i = 1; i < NSTAGE; i++) sb_d[i] = sb_q[i-1];
    if (flush) begin
      for (int i = 0; i < NSTAGE; i++) sb_d[i].valid = 1'b0;
    end
  end

  // Payload only loads with a live response, so it holds while resp_valid is low.
  always_comb begin
    resp_valid_d = sb_q[NSTAGE-1].valid && !flush;
    resp_id_d    = resp_id_q;
    resp_tag_d   = resp_tag_q;
    resp_q_d     = resp_q_q;
    resp_r_d     = resp_r_q;
    resp_dz_d    = resp_dz_q;
    resp_ovf_d   = resp_ovf_q;
    if (resp_valid_d) begin
      resp_id_d  = sb_q[NSTAGE-1].id;
      resp_tag_d = sb_q[NSTAGE-1].tag[TAGW-1:0];
      resp_dz_d  = sb_q[NSTAGE-1].dz;
      resp_ovf_d = sb_q[NSTAGE-1].ovf;
      resp_q_d   = sb_q[NSTAGE-1].dz ? 32'hFFFF_FFFF : div_y;
      resp_r_d   = sb_q[NSTAGE-1].dz ? sb_q[NSTAGE-1].x1_lo : div_z;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush)                        cnt_d = '0;
    else if (issue && !resp_valid_q)  cnt_d = cnt_q + 1'b1;
    else if (!issue && resp_valid_q)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q        <= PTR_A;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_tag_q   <= '0;
      resp_q_q     <= '0;
      resp_r_q     <= '0;
      resp_dz_q    <= 1'b0;
      resp_ovf_q   <= 1'b0;
      for (int i = 0; i < NSTAGE; i++) sb_q[i] <= '0;
    end else begin
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_tag_q   <= resp_tag_d;
      resp_q_q     <= resp_q_d;
      resp_r_q     <= resp_r_d;
      resp_dz_q    <= resp_dz_d;
      resp_ovf_q   <= resp_ovf_d;
      for (int i = 0; i < NSTAGE; i++) sb_q[i] <= sb_d[i];
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_tag   = resp_tag_q;
  assign resp_q     = resp_q_q;
  assign resp_r     = resp_r_q;
  assign resp_dz    = resp_dz_q;
  assign resp_ovf   = resp_ovf_q;
  assign busy       = (cnt_q != '0);

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter NSTAGE, default 16: pipeline depth of the div32 instance, in cycles from operand capture to result.
REQ-002 SHALL have parameter TAGW, default 4: width of the requester tag.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rstn, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have ports a_valid / b_valid, input, 1 each: requester A/B holds an operation.
REQ-006 SHALL have ports a_ready / b_ready, output, 1 each: operation accepted this cycle.
REQ-007 SHALL have ports a_x1 / b_x1, input, 64 each: dividend.
REQ-008 SHALL have ports a_x2 / b_x2, input, 32 each: divisor.
REQ-009 SHALL have ports a_tag / b_tag, input, TAGW each: opaque tag returned with the result.
REQ-010 SHALL have port flush, input, 1: discard all in-flight operations.
REQ-011 SHALL have port resp_valid, output, 1: result valid, single-cycle pulse, no backpressure.
REQ-012 SHALL have port resp_id, output, 1: 0 = A, 1 = B.
REQ-013 SHALL have port resp_tag, output, TAGW: tag of the returned operation.
REQ-014 SHALL have ports resp_q / resp_r, output, 32 each: quotient / remainder.
REQ-015 SHALL have ports resp_dz / resp_ovf, output, 1 each: divide-by-zero / quotient overflow.
REQ-016 SHALL have port busy, output, 1: at least one operation in flight.

Function
REQ-017 SHALL issue at most one operation per cycle (handshake = valid and ready), with a fully pipelined issue rate of one per cycle.
REQ-018 SHALL derive ready combinationally from a_valid, b_valid, the priority pointer and flush; SHALL never assert ready with valid low.
REQ-019 SHALL arbitrate round-robin:
  - If only one requester is valid, it is granted.
  - If both are valid, the pointer owner is granted.
  - After each grant, the pointer moves to the non-granted requester.
  - Pointer reset value = A.
REQ-020 SHALL deassert a_ready and b_ready in any cycle flush = 1.
REQ-021 SHALL carry a valid/id/tag/dz/ovf/low-dividend sideband through an NSTAGE-deep shift register, aligned with the div32 pipeline.
REQ-022 SHALL register the results, so resp_valid rises exactly NSTAGE+1 cycles after the issue edge.
REQ-023 SHALL return responses in issue order, one per issued, unflushed operation.
REQ-024 SHALL set resp_dz = 1 when x2 == 0; in that case resp_q = 32'hFFFFFFFF and resp_r = x1[31:0], regardless of the div32 outputs.
REQ-025 SHALL set resp_ovf = 1 when x2 != 0 and x1[63:32] >= x2; resp_q/resp_r are then the low 32 bits of the div32 outputs.
REQ-026 SHALL, on flush, clear every sideband valid bit and the response register in the same edge; resp_valid is 0 on the following cycle.
REQ-027 SHALL block new issue on flush even when a_valid/b_valid is high in that same cycle.
REQ-028 SHALL keep an in-flight counter (width clog2(NSTAGE+2)) with these updates:
  - +1 on issue, -1 on resp_valid.
  - Issue and response in the same cycle leave it unchanged.
  - Cleared by flush.
  - busy = (counter != 0).
REQ-029 SHALL hold resp_q/resp_r/resp_tag/resp_id/resp_dz/resp_ovf stable when resp_valid = 0.

Reset
REQ-030 SHALL, while rstn = 0, asynchronously force the following to 0: resp_valid, resp_id, resp_tag, resp_q, resp_r, resp_dz, resp_ovf, busy, all sideband valids, the in-flight counter, and pointer = A.
REQ-031 SHALL drive a_ready = b_ready = 0 while rstn = 0.
REQ-032 SHALL produce no response for any operation issued before a mid-operation reset.

Structure
REQ-033 SHALL take the NSTAGE default, the TAGW default and a sideband packed-struct typedef (valid, id, tag, dz, ovf, x1_lo) from shared package div_pkg.
REQ-034 SHALL instantiate exactly one div32 (ports clk, x1[63:0], x2[31:0], y[31:0], z[31:0]) as its only sub-module.

Verification
REQ-035 Single op: A issues x1=100, x2=7, tag=3 -> resp_valid at edge NSTAGE+1 (17 with defaults), id=0, tag=3, q=14, r=2, dz=0, ovf=0.
REQ-036 Contention: A and B both valid for 4 cycles from reset -> grants A, B, A, B; responses on 4 consecutive cycles in that order.
REQ-037 Divide-by-zero: B issues x1=64'h1234, x2=0 -> resp_dz=1, q=32'hFFFFFFFF, r=32'h1234, id=1.
REQ-038 Overflow: x1=64'h1_0000_0000, x2=1 -> resp_ovf=1, dz=0.
REQ-039 Flush: issue 5 ops, flush at cycle 8 with a_valid high -> a_ready=0 that cycle, no resp_valid thereafter, busy=0 next cycle.
REQ-040 Random: 100000 random issues from both requesters -> every response matches x1/x2 and x1%x2 (low 32 bits) with correct id/tag and order; rstn pulsed low mid-run -> no stale responses.
